// File: rtl/riscv_small_fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue and redirect flush for the riscv-small core.
// Optional same-cycle response bypass to decode: define RISCV_SMALL_FETCH_BYPASS_EN.
module riscv_small_fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            clk_en,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [31:0]     if_instr,
   output logic [XLEN-1:0] if_pc
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int DW = CW + 4;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] q_pc    [DEPTH];
   logic [31:0]     q_instr [DEPTH];
   logic [XLEN-1:0] pf_pc   [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [PW-1:0]   pf_rd, pf_wr;
   logic [CW-1:0]   count, outstanding;
   logic [DW-1:0]   discard;

   logic            req_fire, rsp_in, rsp_take, bypass, if_fire, push, pop;
   logic [CW:0]     credit_used;

   always_comb begin
      credit_used    = {1'b0, count} + {1'b0, outstanding};
      imem_req_valid = rst_n & clk_en & ~redirect_valid & (credit_used < DEPTH_C);
      imem_req_addr  = fetch_pc;
      req_fire       = imem_req_valid & imem_req_ready;
      rsp_in         = clk_en & imem_rsp_valid;
      rsp_take       = rsp_in & (discard == '0);
`ifdef RISCV_SMALL_FETCH_BYPASS_EN
      bypass         = rsp_take & (count == '0);
`else
      bypass         = 1'b0;
`endif
      if_valid       = clk_en & ~redirect_valid & ((count != '0) | bypass);
      if_fire        = if_valid & if_ready;
      pop            = if_fire & (count != '0);
      // A bypassed word that decode takes immediately never occupies a slot.
      push           = rsp_take & ~(bypass & if_ready);
      if (count != '0) begin
         if_pc    = q_pc[rd_ptr];
         if_instr = q_instr[rd_ptr];
      end else if (bypass) begin
         if_pc    = pf_pc[pf_rd];
         if_instr = imem_rsp_data;
      end else begin
         if_pc    = '0;
         if_instr = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (clk_en && push) begin
         q_pc[wr_ptr]    <= pf_pc[pf_rd];
         q_instr[wr_ptr] <= imem_rsp_data;
      end
      if (req_fire)
         pf_pc[pf_wr] <= fetch_pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         pf_rd       <= '0;
         pf_wr       <= '0;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else if (clk_en) begin
         if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= discard + DW'(outstanding) - DW'(rsp_in);
            // Flushed fetches carry no useful PC, so the PC FIFO only tracks live fetches.
            pf_rd       <= pf_wr;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + XLEN'(4);
               pf_wr    <= pf_wr + PW'(1);
            end
            if (rsp_in && (discard != '0))
               discard <= discard - DW'(1);
            if (rsp_take)
               pf_rd <= pf_rd + PW'(1);
            if (push)
               wr_ptr <= wr_ptr + PW'(1);
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
            count       <= count + CW'(push) - CW'(pop);
         end
      end
   end

endmodule

// File: tb/tb_riscv_small_fetch_queue.sv
// Randomized bench for riscv_small_fetch_queue against a queue-based behavioural model of the fetch stage.
module tb_riscv_small_fetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0100;

   logic        clk, clk_en, rst_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid, if_ready;
   logic [31:0] if_instr, if_pc;

   riscv_small_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk(clk), .clk_en(clk_en), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Reference model: decode-side queue, every issued address in order, credit counters.
   logic [31:0] mq_pc[$];
   logic [31:0] mq_in[$];
   logic [31:0] m_issued[$];
   int          m_out, m_disc;
   logic [31:0] m_pc;

   // Memory: in-order responses, at least one cycle after acceptance.
   logic [31:0] pend_a[$];
   int          pend_c[$];
   int          cyc = 0;

   int p_en_mode, p_rdy, p_rsp, p_ifr, p_redir;

   task automatic step(input bit force_r, input logic [31:0] force_pc);
      logic        rsp_in, take, byp, e_req, e_if, fire, had, acc;
      logic [31:0] e_pc, e_in, p, acc_addr;
      @(negedge clk);
      case (p_en_mode)
         0:       clk_en = 1'b1;
         1:       clk_en = ~clk_en;
         default: clk_en = ($urandom_range(99) < 70);
      endcase
      imem_req_ready = ($urandom_range(99) < p_rdy);
      if_ready       = ($urandom_range(99) < p_ifr);
      redirect_valid = force_r || ($urandom_range(99) < p_redir);
      redirect_pc    = force_r ? force_pc : $urandom;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (clk_en && pend_a.size() > 0 && pend_c[0] < cyc && $urandom_range(99) < p_rsp) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = word_of(pend_a.pop_front());
         void'(pend_c.pop_front());
      end
      #1;
      rsp_in = clk_en && imem_rsp_valid;
      take   = rsp_in && (m_disc == 0);
      byp    = 1'b0;
`ifdef RISCV_SMALL_FETCH_BYPASS_EN
      byp    = take && (mq_pc.size() == 0);
`endif
      e_req = clk_en && !redirect_valid && (mq_pc.size() + m_out < DEPTH);
      e_if  = clk_en && !redirect_valid && (mq_pc.size() > 0 || byp);
      e_pc  = '0;
      e_in  = '0;
      if (mq_pc.size() > 0) begin
         e_pc = mq_pc[0];
         e_in = mq_in[0];
      end else if (byp) begin
         e_pc = m_issued[0];
         e_in = imem_rsp_data;
      end
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
      chk("req_addr", imem_req_addr, m_pc);
      chk("if_valid", {31'b0, if_valid}, {31'b0, e_if});
      if (e_if) begin
         chk("if_pc", if_pc, e_pc);
         chk("if_instr", if_instr, e_in);
      end
      if (clk_en && if_valid && if_ready)
         chk("pair", if_instr, word_of(if_pc));
      acc      = clk_en && imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      @(posedge clk);
      if (acc) begin
         pend_a.push_back(acc_addr);
         pend_c.push_back(cyc);
      end
      cyc++;
      if (clk_en) begin
         fire = e_if && if_ready;
         had  = mq_pc.size() > 0;
         if (redirect_valid) begin
            if (rsp_in) void'(m_issued.pop_front());
            m_disc = m_disc + m_out - (rsp_in ? 1 : 0);
            m_out  = 0;
            mq_pc.delete();
            mq_in.delete();
            m_pc   = redirect_pc & ~32'h3;
         end else begin
            p = '0;
            if (rsp_in) begin
               p = m_issued.pop_front();
               if (m_disc > 0) m_disc--;
               else m_out--;
            end
            if (fire && had) begin
               void'(mq_pc.pop_front());
               void'(mq_in.pop_front());
            end
            if (take && !(byp && if_ready)) begin
               mq_pc.push_back(p);
               mq_in.push_back(imem_rsp_data);
            end
            if (e_req && imem_req_ready) begin
               m_issued.push_back(m_pc);
               m_pc = m_pc + 32'd4;
               m_out++;
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; clk_en = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
      imem_rsp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
      m_out = 0; m_disc = 0; m_pc = RPC;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_req_addr", imem_req_addr, RPC);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_if_instr", if_instr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming: 1-cycle memory, decode always ready.
      p_en_mode = 0; p_rdy = 100; p_rsp = 100; p_ifr = 100; p_redir = 0;
      repeat (30) step(1'b0, '0);
      // Decode stall fills the credits, then drains in order.
      p_ifr = 0;   repeat (10) step(1'b0, '0);
      p_ifr = 100; repeat (20) step(1'b0, '0);
      // Redirect with fetches in flight: late responses are dropped.
      p_rsp = 0;   repeat (3) step(1'b0, '0);
      step(1'b1, 32'h0000_2000);
      p_rsp = 100; repeat (20) step(1'b0, '0);
      // Redirect coinciding with a response and a pop.
      step(1'b1, 32'h0000_3000);
      repeat (10) step(1'b0, '0);
      // Misaligned target at the top of memory: wraps to 0.
      step(1'b1, 32'hFFFF_FFFF);
      repeat (10) step(1'b0, '0);
      // clk_en toggling with random memory back-pressure.
      p_en_mode = 1; p_rdy = 50; p_rsp = 60;
      repeat (200) step(1'b0, '0);
      // Fully random traffic.
      p_en_mode = 2; p_rdy = 70; p_rsp = 60; p_ifr = 60; p_redir = 4;
      repeat (3000) step(1'b0, '0);
      p_en_mode = 0; p_rsp = 100; p_ifr = 100; p_redir = 0;
      repeat (30) step(1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
